sdc_host_arb: RTL and testbench

- Round-robin arbiter that shares the single host port of the SDRAM controller top among NUM_REQ requesters (CPU, DMA, video fetch, etc.).
- Sits between the requesters and the controller's sdr_* host interface.
- Grants one request at a time and latches its address, length and direction.
- Steers the write-data, per-beat handshakes and read data for that transaction, and releases the port when the burst completes or a watchdog expires.

---
 rtl/sdc_host_arb.sv | 179 +++++++++++++++++
 tb/tb_sdc_host_arb.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_host_arb.sv
// Round-robin arbiter sharing the SDRAM controller host port among NUM_REQ requesters.
// Latches the winner's request fields, steers per-beat traffic, and aborts stalled bursts.
module sdc_host_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TO_CYC  = 255
) (
  input  logic                      mclk,
  input  logic                      s_resetn,
  input  logic [NUM_REQ-1:0]        m_req,
  input  logic [NUM_REQ*ADDR_W-1:0] m_req_adr,
  input  logic [NUM_REQ*2-1:0]      m_req_len,
  input  logic [NUM_REQ-1:0]        m_req_wr_n,
  input  logic [NUM_REQ*DATA_W-1:0] m_wr_data,
  input  logic [NUM_REQ*4-1:0]      m_wr_en_n,
  output logic [NUM_REQ-1:0]        m_req_ack,
  output logic [NUM_REQ-1:0]        m_rd_valid,
  output logic [NUM_REQ-1:0]        m_wr_next,
  output logic [DATA_W-1:0]         m_rd_data,
  output logic [NUM_REQ-1:0]        m_grant,
  output logic                      arb_err,
  input  logic                      sdr_init_done,
  output logic                      sdr_req,
  output logic [ADDR_W-1:0]         sdr_req_adr,
  output logic [1:0]                sdr_req_len,
  output logic                      sdr_req_wr_n,
  output logic [DATA_W-1:0]         sdr_wr_data,
  output logic [3:0]                sdr_wr_en_n,
  input  logic                      sdr_req_ack,
  input  logic                      sdr_rd_valid,
  input  logic                      sdr_wr_next,
  input  logic [DATA_W-1:0]         sdr_rd_data
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  WdMax = 8'(TO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [1:0]          len_q, len_d;
  logic                wr_n_q, wr_n_d;
  logic                req_q, req_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [7:0]          wd_q, wd_d;
  logic                err_q, err_d;

  logic                found;
  logic [PtrW-1:0]     win;
  logic [PtrW-1:0]     scan_idx;
  logic                beat;

  // Scan upward from the pointer with wrap; first hit wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && m_req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign beat = wr_n_q ? sdr_rd_valid : sdr_wr_next;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    adr_d   = adr_q;
    len_d   = len_q;
    wr_n_d  = wr_n_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sdr_init_done && found) begin
          state_d      = StReq;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          adr_d        = m_req_adr[win*ADDR_W +: ADDR_W];
          len_d        = m_req_len[win*2 +: 2];
          wr_n_d       = m_req_wr_n[win];
          req_d        = 1'b1;
          ptr_d        = (win == PtrW'(NUM_REQ - 1)) ? '0 : win + PtrW'(1);
          cnt_d        = '0;
          wd_d         = '0;
        end
      end
      StReq, StXfer: begin
        if (beat && (cnt_q == len_q)) begin
          // Final beat wins even when it lands together with the ack.
          state_d = StIdle;
          grant_d = '0;
          req_d   = 1'b0;
          cnt_d   = '0;
          wd_d    = '0;
        end else begin
          if (beat) cnt_d = cnt_q + 2'd1;
          if ((state_q == StReq) && sdr_req_ack) begin
            req_d   = 1'b0;
            state_d = StXfer;
          end
          if (beat || sdr_req_ack) begin
            wd_d = '0;
          end else if (wd_q == WdMax) begin
            state_d = StIdle;
            grant_d = '0;
            req_d   = 1'b0;
            cnt_d   = '0;
            wd_d    = '0;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      adr_q   <= '0;
      len_q   <= '0;
      wr_n_q  <= 1'b1;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      wr_n_q  <= wr_n_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sdr_wr_data = '0;
    sdr_wr_en_n = 4'hF;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sdr_wr_data = m_wr_data[i*DATA_W +: DATA_W];
        sdr_wr_en_n = m_wr_en_n[i*4 +: 4];
      end
    end
  end

  assign m_req_ack    = {NUM_REQ{sdr_req_ack}} & grant_q;
  assign m_rd_valid   = {NUM_REQ{sdr_rd_valid}} & grant_q;
  assign m_wr_next    = {NUM_REQ{sdr_wr_next}} & grant_q;
  assign m_rd_data    = sdr_rd_data;
  assign m_grant      = grant_q;
  assign arb_err      = err_q;
  assign sdr_req      = req_q;
  assign sdr_req_adr  = adr_q;
  assign sdr_req_len  = len_q;
  assign sdr_req_wr_n = wr_n_q;

endmodule

// File: tb/tb_sdc_host_arb.sv
// Directed bench for sdc_host_arb: expected grants and read data are queued at stimulus
// time and compared when the arbiter presents them.
module tb_sdc_host_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 255;

  logic mclk = 1'b0;
  logic s_resetn = 1'b0;
  always #5 mclk = ~mclk;

  logic [NR-1:0]    m_req;
  logic [NR-1:0]    m_req_wr_n;
  logic [AW-1:0]    adr_a [NR];
  logic [1:0]       len_a [NR];
  logic [DW-1:0]    wd_a  [NR];
  logic [3:0]       en_a  [NR];
  logic [NR*AW-1:0] m_req_adr;
  logic [NR*2-1:0]  m_req_len;
  logic [NR*DW-1:0] m_wr_data;
  logic [NR*4-1:0]  m_wr_en_n;
  logic [NR-1:0]    m_req_ack, m_rd_valid, m_wr_next, m_grant;
  logic [DW-1:0]    m_rd_data;
  logic             arb_err;
  logic             sdr_init_done, sdr_req, sdr_req_wr_n, sdr_req_ack, sdr_rd_valid, sdr_wr_next;
  logic [AW-1:0]    sdr_req_adr;
  logic [1:0]       sdr_req_len;
  logic [DW-1:0]    sdr_wr_data, sdr_rd_data;
  logic [3:0]       sdr_wr_en_n;

  always_comb begin
    m_req_adr = '0;
    m_req_len = '0;
    m_wr_data = '0;
    m_wr_en_n = '0;
    for (int i = 0; i < NR; i++) begin
      m_req_adr[i*AW +: AW] = adr_a[i];
      m_req_len[i*2 +: 2]   = len_a[i];
      m_wr_data[i*DW +: DW] = wd_a[i];
      m_wr_en_n[i*4 +: 4]   = en_a[i];
    end
  end

  sdc_host_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) dut (
    .mclk          (mclk),
    .s_resetn      (s_resetn),
    .m_req         (m_req),
    .m_req_adr     (m_req_adr),
    .m_req_len     (m_req_len),
    .m_req_wr_n    (m_req_wr_n),
    .m_wr_data     (m_wr_data),
    .m_wr_en_n     (m_wr_en_n),
    .m_req_ack     (m_req_ack),
    .m_rd_valid    (m_rd_valid),
    .m_wr_next     (m_wr_next),
    .m_rd_data     (m_rd_data),
    .m_grant       (m_grant),
    .arb_err       (arb_err),
    .sdr_init_done (sdr_init_done),
    .sdr_req       (sdr_req),
    .sdr_req_adr   (sdr_req_adr),
    .sdr_req_len   (sdr_req_len),
    .sdr_req_wr_n  (sdr_req_wr_n),
    .sdr_wr_data   (sdr_wr_data),
    .sdr_wr_en_n   (sdr_wr_en_n),
    .sdr_req_ack   (sdr_req_ack),
    .sdr_rd_valid  (sdr_rd_valid),
    .sdr_wr_next   (sdr_wr_next),
    .sdr_rd_data   (sdr_rd_data)
  );

  typedef struct {
    int          idx;
    logic [AW-1:0] adr;
    logic [1:0]  len;
    logic        wr_n;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input int idx);
    txn_t t;
    t.idx  = idx;
    t.adr  = adr_a[idx];
    t.len  = len_a[idx];
    t.wr_n = m_req_wr_n[idx];
    exp_q.push_back(t);
  endtask

  // Waits for sdr_req, then compares the latched request against the oldest queued one.
  task automatic wait_grant(input int budget, output int waited);
    txn_t t;
    waited = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge mclk);
      if (sdr_req) break;
      waited++;
    end
    if (!sdr_req) check("grant_timeout", 64'(sdr_req), 64'd1);
    else if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
    else begin
      t = exp_q.pop_front();
      check("grant_owner", 64'(m_grant), 64'd1 << t.idx);
      check("grant_adr", 64'(sdr_req_adr), 64'(t.adr));
      check("grant_len", 64'(sdr_req_len), 64'(t.len));
      check("grant_wr_n", 64'(sdr_req_wr_n), 64'(t.wr_n));
    end
  endtask

  task automatic rd_beat(input int idx, input logic [DW-1:0] d);
    sdr_rd_valid = 1'b1;
    sdr_rd_data  = d;
    rd_q.push_back(d);
    #1;
    check("rd_route", 64'(m_rd_valid), 64'd1 << idx);
    if (m_rd_valid != '0 && rd_q.size() != 0) check("rd_data", 64'(m_rd_data), 64'(rd_q.pop_front()));
    @(negedge mclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, 64'(sdr_req), 64'd0);
    check({tag, "_adr"}, 64'(sdr_req_adr), 64'd0);
    check({tag, "_len"}, 64'(sdr_req_len), 64'd0);
    check({tag, "_wr_n"}, 64'(sdr_req_wr_n), 64'd1);
    check({tag, "_grant"}, 64'(m_grant), 64'd0);
    check({tag, "_err"}, 64'(arb_err), 64'd0);
    check({tag, "_en_n"}, 64'(sdr_wr_en_n), 64'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int hi;
    int cnt;
    int errs;
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    m_req = '0;
    m_req_wr_n = '1;
    for (int i = 0; i < NR; i++) begin
      adr_a[i] = '0;
      len_a[i] = '0;
      wd_a[i]  = '0;
      en_a[i]  = 4'hF;
    end
    sdr_init_done = 1'b1;
    sdr_req_ack   = 1'b0;
    sdr_rd_valid  = 1'b0;
    sdr_wr_next   = 1'b0;
    sdr_rd_data   = '0;
    repeat (2) @(negedge mclk);
    check_reset_vals("rst");
    s_resetn = 1'b1;
    @(negedge mclk);

    // Single read, requester 1, four beats.
    adr_a[1] = 22'h00100;
    len_a[1] = 2'd3;
    m_req_wr_n[1] = 1'b1;
    m_req[1] = 1'b1;
    expect_txn(1);
    wait_grant(8, w);
    check("rd_latency", 64'(w), 64'd0);
    sdr_req_ack = 1'b1;
    #1 check("rd_ack", 64'(m_req_ack), 64'b0010);
    @(negedge mclk);
    sdr_req_ack = 1'b0;
    m_req[1] = 1'b0;
    adr_a[1] = 22'h3FFFFF;
    len_a[1] = 2'd0;
    check("rd_req_low", 64'(sdr_req), 64'd0);
    for (int b = 0; b < 4; b++) rd_beat(1, 32'hA5A5_0000 + 32'(b));
    #1 check("rd_drop_idle", 64'(m_rd_valid), 64'd0);
    sdr_rd_valid = 1'b0;
    check("rd_done_grant", 64'(m_grant), 64'd0);
    check("rd_adr_hold", 64'(sdr_req_adr), 64'h00100);

    s_resetn = 1'b0;
    @(negedge mclk);
    s_resetn = 1'b1;
    @(negedge mclk);

    // Round robin over four single-beat writers.
    for (int i = 0; i < NR; i++) begin
      adr_a[i] = 22'(i * 'h1111 + 'h20);
      len_a[i] = 2'd0;
      m_req_wr_n[i] = 1'b0;
      wd_a[i] = 32'hD0D0_0000 + 32'(i);
      en_a[i] = 4'(i + 3);
    end
    m_req = '1;
    for (int k = 0; k < 5; k++) expect_txn(ord[k]);
    for (int k = 0; k < 5; k++) begin
      wait_grant(8, w);
      check("rr_gap", 64'(w), 64'd0);
      check("rr_wr_data", 64'(sdr_wr_data), 64'(wd_a[ord[k]]));
      check("rr_wr_en_n", 64'(sdr_wr_en_n), 64'(en_a[ord[k]]));
      sdr_req_ack = 1'b1;
      if (k == 4) m_req = '0;
      #1 check("rr_ack", 64'(m_req_ack), 64'd1 << ord[k]);
      @(negedge mclk);
      sdr_req_ack = 1'b0;
      sdr_wr_next = 1'b1;
      #1 check("rr_wr_next", 64'(m_wr_next), 64'd1 << ord[k]);
      @(negedge mclk);
      sdr_wr_next = 1'b0;
      check("rr_idle_grant", 64'(m_grant), 64'd0);
      check("rr_idle_en_n", 64'(sdr_wr_en_n), 64'hF);
    end

    // Init gating.
    sdr_init_done = 1'b0;
    adr_a[2] = 22'h2ABCD;
    len_a[2] = 2'd0;
    m_req_wr_n[2] = 1'b1;
    m_req[2] = 1'b1;
    hi = 0;
    repeat (50) begin
      @(negedge mclk);
      if (sdr_req) hi++;
    end
    check("init_block", 64'(hi), 64'd0);
    expect_txn(2);
    sdr_init_done = 1'b1;
    wait_grant(4, w);
    check("init_latency", 64'(w), 64'd0);
    sdr_req_ack = 1'b1;
    m_req[2] = 1'b0;
    @(negedge mclk);
    sdr_req_ack = 1'b0;
    rd_beat(2, 32'h1234_5678);
    sdr_rd_valid = 1'b0;
    check("init_done_grant", 64'(m_grant), 64'd0);

    // Ack coincident with the only beat.
    adr_a[3] = 22'h3C3C3;
    len_a[3] = 2'd0;
    m_req_wr_n[3] = 1'b0;
    m_req[3] = 1'b1;
    expect_txn(3);
    wait_grant(8, w);
    sdr_req_ack = 1'b1;
    sdr_wr_next = 1'b1;
    m_req[3] = 1'b0;
    #1;
    check("co_ack", 64'(m_req_ack), 64'b1000);
    check("co_wr_next", 64'(m_wr_next), 64'b1000);
    @(negedge mclk);
    sdr_req_ack = 1'b0;
    sdr_wr_next = 1'b0;
    check("co_grant", 64'(m_grant), 64'd0);
    check("co_req", 64'(sdr_req), 64'd0);
    check("co_en_n", 64'(sdr_wr_en_n), 64'hF);

    // Watchdog: requester 0 is never acked; requester 1 follows.
    for (int i = 0; i < 2; i++) begin
      len_a[i] = 2'd0;
      m_req_wr_n[i] = 1'b1;
    end
    m_req[1:0] = 2'b11;
    expect_txn(0);
    expect_txn(1);
    wait_grant(8, w);
    cnt = 1;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge mclk);
      if (arb_err) errs++;
      if (!sdr_req) break;
      cnt++;
    end
    check("wd_cycles", 64'(cnt), 64'(TO));
    check("wd_err", 64'(arb_err), 64'd1);
    check("wd_grant_clr", 64'(m_grant), 64'd0);
    m_req[0] = 1'b0;
    wait_grant(4, w);
    check("wd_next_gap", 64'(w), 64'd0);
    check("wd_err_pulse", 64'(arb_err), 64'd0);
    check("wd_err_count", 64'(errs), 64'd1);
    sdr_req_ack = 1'b1;
    m_req[1] = 1'b0;
    @(negedge mclk);
    sdr_req_ack = 1'b0;
    rd_beat(1, 32'hCAFE_F00D);
    sdr_rd_valid = 1'b0;

    // Reset in the middle of a four-beat read.
    adr_a[2] = 22'h15555;
    len_a[2] = 2'd3;
    m_req_wr_n[2] = 1'b1;
    m_req[2] = 1'b1;
    expect_txn(2);
    wait_grant(8, w);
    sdr_req_ack = 1'b1;
    @(negedge mclk);
    sdr_req_ack = 1'b0;
    m_req[2] = 1'b0;
    rd_beat(2, 32'h0BEA_0001);
    sdr_rd_valid = 1'b1;
    sdr_rd_data = 32'h0BEA_0002;
    #2 s_resetn = 1'b0;
    #1;
    check_reset_vals("mid");
    check("mid_rd_valid", 64'(m_rd_valid), 64'd0);
    sdr_rd_valid = 1'b0;
    @(negedge mclk);
    m_req = '1;
    expect_txn(0);
    s_resetn = 1'b1;
    wait_grant(4, w);
    check("mid_first_gap", 64'(w), 64'd0);
    m_req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
